// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the fetch, data and external-memory handshakes
//               around the shared memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Instruction-fetch side
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          imem_ready;
  // Data-memory side
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ready;
  // External single-ported memory
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  // Hazard-unit stall requests
  logic          stall_if;
  logic          stall_mem;

  // Arbiter view
  modport slave (
    input  imem_req, imem_addr,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  mem_rdata, mem_ready,
    output imem_rdata, imem_ready,
    output dmem_rdata, dmem_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_mem
  );

  // Pipeline / memory environment view
  modport master (
    output imem_req, imem_addr,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output mem_rdata, mem_ready,
    input  imem_rdata, imem_ready,
    input  dmem_rdata, dmem_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_mem
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one variable-latency memory port
//               between instruction fetch and data memory, with one-cycle
//               completion pulses and combinational stall requests.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mem_port_arbiter_if.slave      bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY_D = 3'd1,
    S_BUSY_I = 3'd2,
    S_RESP_D = 3'd3,
    S_RESP_I = 3'd4
  } state_t;

  // Encoding of the last side that owned the port
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_t        state_q;
  logic          last_grant_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] imem_rdata_q;
  logic [DW-1:0] dmem_rdata_q;
  logic          imem_ready_q;
  logic          dmem_ready_q;

  logic          gnt_data;
  logic          gnt_fetch;

  // Grant decision; the side completing in RESP is never regranted directly
  always_comb begin
    gnt_data  = 1'b0;
    gnt_fetch = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.dmem_req && (!bus.imem_req || (last_grant_q == GNT_I))) begin
          gnt_data = 1'b1;
        end else if (bus.imem_req) begin
          gnt_fetch = 1'b1;
        end
      end
      S_RESP_D: gnt_fetch = bus.imem_req;
      S_RESP_I: gnt_data  = bus.dmem_req;
      default: begin
        gnt_data  = 1'b0;
        gnt_fetch = 1'b0;
      end
    endcase
  end

  // Port FSM with registered handshake outputs and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= GNT_I;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
      imem_ready_q <= 1'b0;
      dmem_ready_q <= 1'b0;
    end else begin
      imem_ready_q <= 1'b0;
      dmem_ready_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RESP_D, S_RESP_I: begin
          if (gnt_data) begin
            state_q      <= S_BUSY_D;
            last_grant_q <= GNT_D;
            mem_req_q    <= 1'b1;
            mem_we_q     <= bus.dmem_we;
            mem_addr_q   <= bus.dmem_addr;
            mem_wdata_q  <= bus.dmem_wdata;
          end else if (gnt_fetch) begin
            state_q      <= S_BUSY_I;
            last_grant_q <= GNT_I;
            mem_req_q    <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= bus.imem_addr;
          end else begin
            state_q      <= S_IDLE;
          end
        end
        S_BUSY_D: begin
          if (bus.mem_ready) begin
            dmem_rdata_q <= bus.mem_rdata;
            dmem_ready_q <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            state_q      <= S_RESP_D;
          end
        end
        S_BUSY_I: begin
          if (bus.mem_ready) begin
            imem_rdata_q <= bus.mem_rdata;
            imem_ready_q <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            state_q      <= S_RESP_I;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.imem_rdata = imem_rdata_q;
  assign bus.dmem_rdata = dmem_rdata_q;
  assign bus.imem_ready = imem_ready_q;
  assign bus.dmem_ready = dmem_ready_q;

  // Stall requests stay combinational so they fall in the ready cycle itself
  assign bus.stall_if  = bus.imem_req & ~imem_ready_q;
  assign bus.stall_mem = bus.dmem_req & ~dmem_ready_q;

endmodule
`default_nettype wire
